spi_master: RTL

- Single-byte SPI master: the initiator end of the link served by the team's SPI slave.
- On a start strobe it:
  - asserts ssn;
  - generates sck at a programmable rate with selectable CPOL/CPHA;
  - shifts one byte out MSB-first on mosi while shifting one byte in from miso;
  - returns the received byte with a one-cycle done pulse.
- Sits between the CPU register file (data/spcon/spibr) and the external SPI pins.

---
 rtl/spi_pkg.sv | 7 +
 rtl/spi_baud_gen.sv | 18 +
 rtl/spi_master.sv | 132 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI state encoding, spcon bit positions and default transfer width
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_e;
  localparam int SPCON_CPOL = 2;
  localparam int SPCON_CPHA = 1;
  localparam int SPI_DATA_W = 8;
endpackage

// File: rtl/spi_baud_gen.sv
// spi_baud_gen: sck half-period down-counter (ports: clk, rst, en count enable, load zeroes counter, reload half-period-1, tick when count hits zero)
module spi_baud_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] reload,
  output logic             tick
);
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  always_comb begin
    tick = en && div_cnt_q == '0;
    div_cnt_d = load ? '0 : tick ? reload : en ? div_cnt_q - DIV_W'(1) : div_cnt_q;
  end
  always_ff @(posedge clk) div_cnt_q <= rst ? '0 : div_cnt_d;
endmodule

// File: rtl/spi_master.sv
// spi_master: single-byte SPI master (ports: clk, rst, start/data/spcon/spibr from CPU, miso in; mosi/sck/ssn pins, rx_data/busy/done status out)
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [7:0]        spcon,
  input  logic [DIV_W-1:0]  spibr,
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic              ssn,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done
);
  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);
  spi_state_e state_q, state_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d, edge_n;
  logic [DIV_W-1:0] br_q, br_d;
  logic arm_q, arm_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic mosi_q, mosi_d, sck_q, sck_d, ssn_q, ssn_d, busy_q, busy_d, done_q, done_d;
  logic accept, tick, edge_ev, last, unused_spcon;
  assign unused_spcon = ^{spcon[7:3], spcon[0]};
  spi_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk(clk),
    .rst(rst),
    .en(state_q != IDLE),
    .load(accept),
    .reload(br_q),
    .tick(tick)
  );
  // The first tick after start only opens the setup half-period (arm); sck edges begin on the next one.
  // A start in the done cycle is refused so the earliest new transfer begins the cycle after done.
  always_comb begin
    state_d = state_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    rx_data_d = rx_data_q;
    edge_cnt_d = edge_cnt_q;
    br_d = br_q;
    arm_d = arm_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    mosi_d = mosi_q;
    sck_d = sck_q;
    ssn_d = ssn_q;
    busy_d = busy_q;
    done_d = 1'b0;
    accept = start && state_q == IDLE && !done_q;
    edge_n = edge_cnt_q + EW'(1);
    last = edge_n == LAST_EDGE;
    edge_ev = tick && (state_q == XFER || (state_q == SETUP && arm_q));
    if (state_q == IDLE) sck_d = spcon[SPCON_CPOL];
    if (accept) begin
      state_d = SETUP;
      tx_sh_d = spcon[SPCON_CPHA] ? data : data << 1;
      mosi_d = spcon[SPCON_CPHA] ? mosi_q : data[DATA_W-1];
      cpol_d = spcon[SPCON_CPOL];
      cpha_d = spcon[SPCON_CPHA];
      br_d = spibr;
      edge_cnt_d = '0;
      arm_d = 1'b0;
      ssn_d = 1'b0;
      busy_d = 1'b1;
    end
    if (state_q == SETUP && tick) arm_d = 1'b1;
    if (edge_ev) begin
      sck_d = ~sck_q;
      edge_cnt_d = edge_n;
      state_d = last ? HOLD : XFER;
      if (edge_n[0] ^ cpha_q) rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
      if (cpha_q ? edge_n[0] : !edge_n[0] && !last) begin
        mosi_d = tx_sh_q[DATA_W-1];
        tx_sh_d = tx_sh_q << 1;
      end
    end
    if (state_q == HOLD && tick) begin
      state_d = IDLE;
      ssn_d = 1'b1;
      busy_d = 1'b0;
      done_d = 1'b1;
      rx_data_d = rx_sh_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_data_q <= '0;
      edge_cnt_q <= '0;
      br_q <= '0;
      arm_q <= 1'b0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      mosi_q <= 1'b0;
      sck_q <= 1'b0;
      ssn_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      edge_cnt_q <= edge_cnt_d;
      br_q <= br_d;
      arm_q <= arm_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      mosi_q <= mosi_d;
      sck_q <= sck_d;
      ssn_q <= ssn_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign mosi = mosi_q;
  assign sck = sck_q;
  assign ssn = ssn_q;
  assign rx_data = rx_data_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
